weak_signal_agc_snr: RTL and testbench
======================================

WEAK_SIGNAL_AGC_SNR -- requirements
Module: weak_signal_agc_snr

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of time-multiplexed detector channels (1..16).
REQ-002 SHALL have parameter MAG_WIDTH, default 24, magnitude sample width (unsigned).
REQ-003 SHALL have parameter WIN_LOG2, default 8, window length 2^WIN_LOG2 samples per channel.
REQ-004 SHALL have parameter GAIN_MAX, default 15, highest gain shift code.
REQ-005 SHALL have parameters LOW_TH = 24'h010000 and HIGH_TH = 24'h700000, window-mean AGC thresholds.
REQ-006 SHALL have parameter SETTLE_SAMPLES, default 16, samples discarded per channel after a gain step.
REQ-007 SHALL have ports clk in 1, single clock; rst in 1, asynchronous, active-high reset.
REQ-008 SHALL have ports mag_in in MAG_WIDTH, mag_ch in CW=max(1,$clog2(NUM_CH)), mag_locked in 1, mag_valid in 1.
REQ-009 SHALL have ports agc_enable in 1 and manual_gain in 4, the gain code applied to all channels when AGC is off.
REQ-010 SHALL have output gain_out, 4*NUM_CH bits, per-channel gain codes with channel k in bits [4k+3:4k].
REQ-011 SHALL have outputs res_valid 1, res_ch CW, res_mean MAG_WIDTH, res_noise MAG_WIDTH, res_snr 8 (log2 ratio, Q5.3), res_locked 1.
REQ-012 SHALL have output err_ch 1, a sticky bit set on an out-of-range channel index.

Function
REQ-013 Each mag_valid=1 cycle SHALL update only the channel selected by mag_ch.
REQ-014 Per-channel state SHALL be ACCUM or SETTLE, with a sample counter, sum S (MAG_WIDTH+WIN_LOG2 bits, no overflow possible), deviation sum D, reference mean R and lock-AND flag.
REQ-015 In ACCUM, each sample SHALL add mag_in to S, add |mag_in - R| to D, and AND mag_locked into the lock flag.
REQ-016 On the 2^WIN_LOG2-th ACCUM sample, mean SHALL equal S>>WIN_LOG2 and noise SHALL equal max(D>>WIN_LOG2, 1).
REQ-017 At window end, R SHALL take the new mean, and S, D, the counter and the lock flag SHALL clear.
REQ-018 res_valid SHALL pulse exactly 2 clk cycles after the mag_valid cycle that closes a window.
REQ-019 res_ch, res_mean, res_noise, res_snr and res_locked SHALL be held until the next res_valid.
REQ-020 res_snr SHALL equal 8*(msb(mean)-msb(noise)) plus the 3 bits below each MSB (mean minus noise), saturated to 0..255; mean=0 SHALL give 0.
REQ-021 With agc_enable=1 at window end: if mean<LOW_TH and gain<GAIN_MAX, gain SHALL increase by 1 and R SHALL double, saturating at all-ones.
REQ-022 Otherwise with agc_enable=1 at window end: if mean>HIGH_TH and gain>0, gain SHALL decrease by 1 and R SHALL halve; otherwise gain SHALL hold.
REQ-023 A gain change SHALL move the channel to SETTLE; the next SETTLE_SAMPLES samples of that channel SHALL be discarded, then the channel SHALL return to ACCUM.
REQ-024 The window closing at a gain change SHALL still report its result (pre-change gain).
REQ-025 With agc_enable=0, every gain_out field SHALL equal manual_gain one cycle later, no channel SHALL enter SETTLE, and any channel in SETTLE SHALL return to ACCUM.
REQ-026 On an agc_enable 0->1 transition, each channel's AGC SHALL start from the current manual_gain.
REQ-027 A sample with mag_ch>=NUM_CH SHALL be ignored and SHALL set err_ch; only reset SHALL clear err_ch.
REQ-028 Back-to-back window closes on different channels in consecutive cycles SHALL each produce their own res_valid pulse, in input order.

Reset
REQ-029 While rst=1: all counters, S, D and R SHALL be 0; state SHALL be ACCUM; lock flags SHALL be 1.
REQ-030 While rst=1: gain_out fields SHALL be 4; res_valid, err_ch, res_* SHALL be 0.
REQ-031 Assertion of rst mid-window SHALL discard partial sums, and no res_valid SHALL be emitted for that window.

Verification (NUM_CH=2, WIN_LOG2=2, SETTLE_SAMPLES=2)
REQ-032 Ch0 4x 0x200000, locked, agc on -> res_valid 2 cycles after the 4th sample, res_mean=0x200000, res_noise=0x200000 (R=0), gain0 holds 4.
REQ-033 Ch1 4x 0x001000, agc on -> gain1 becomes 5; the next 2 ch1 samples are ignored; the 3rd starts a new window.
REQ-034 Ch0 4x 0x7FFFFF -> gain0 decrements to 3; a second window with one mag_locked=0 sample -> res_locked=0.
REQ-035 Interleaved ch0/ch1 samples with both windows closing on consecutive cycles -> two res_valid pulses, res_ch 0 then 1.
REQ-036 mag_ch=3 sample -> err_ch=1, no state change; agc_enable=0, manual_gain=9 -> both gain fields=9 next cycle; rst mid-window -> no result, gains=4.

Source files
------------

// File: rtl/weak_signal_agc_snr.sv
// Time-multiplexed weak-signal detector: per-channel windowed mean and mean
// absolute deviation, log2 SNR estimate, and threshold AGC with post-step settling.
module weak_signal_agc_snr #(
    parameter int NUM_CH = 2,
    parameter int MAG_WIDTH = 24,
    parameter int WIN_LOG2 = 8,
    parameter int GAIN_MAX = 15,
    parameter logic [MAG_WIDTH-1:0] LOW_TH = 24'h010000,
    parameter logic [MAG_WIDTH-1:0] HIGH_TH = 24'h700000,
    parameter int SETTLE_SAMPLES = 16,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAG_WIDTH-1:0]   mag_in,
    input  logic [CW-1:0]          mag_ch,
    input  logic                   mag_locked,
    input  logic                   mag_valid,
    input  logic                   agc_enable,
    input  logic [3:0]             manual_gain,
    output logic [4*NUM_CH-1:0]    gain_out,
    output logic                   res_valid,
    output logic [CW-1:0]          res_ch,
    output logic [MAG_WIDTH-1:0]   res_mean,
    output logic [MAG_WIDTH-1:0]   res_noise,
    output logic [7:0]             res_snr,
    output logic                   res_locked,
    output logic                   err_ch
);

    localparam int SUM_W = MAG_WIDTH + WIN_LOG2;
    localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int CNT_W = ((WIN_LOG2 > SET_W) ? WIN_LOG2 : SET_W) + 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << WIN_LOG2) - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam bit HAS_SETTLE = (SETTLE_SAMPLES > 0);

    typedef enum logic {ACCUM, SETTLE} ch_state_t;

    ch_state_t            state_q [NUM_CH];
    logic [CNT_W-1:0]     cnt_q   [NUM_CH];
    logic [SUM_W-1:0]     s_q     [NUM_CH];
    logic [SUM_W-1:0]     d_q     [NUM_CH];
    logic [MAG_WIDTH-1:0] r_q     [NUM_CH];
    logic                 lock_q  [NUM_CH];
    logic [3:0]           gain_q  [NUM_CH];
    logic                 agc_q;

    ch_state_t            cur_state;
    logic [CNT_W-1:0]     cur_cnt;
    logic [SUM_W-1:0]     cur_s, cur_d, new_s, new_d;
    logic [MAG_WIDTH-1:0] cur_r, diff, mean_w, noise_w, next_r;
    logic                 cur_lock, new_lock;
    logic [3:0]           cur_gain;
    logic                 in_range, hit, win_end, agc_run, gain_up, gain_dn;

    logic                 p1_valid, p1_lock;
    logic [CW-1:0]        p1_ch;
    logic [MAG_WIDTH-1:0] p1_mean, p1_noise;
    int                   snr_pm, snr_pn, snr_v;
    logic [7:0]           snr_calc;

    function automatic int msb_pos(input logic [MAG_WIDTH-1:0] x);
        msb_pos = 0;
        for (int i = 0; i < MAG_WIDTH; i++)
            if (x[i]) msb_pos = i;
    endfunction

    // Three bits directly below the leading one, zero-padded for small values.
    function automatic logic [2:0] frac_bits(input logic [MAG_WIDTH-1:0] x, input int p);
        logic [MAG_WIDTH+2:0] ext;
        ext = {x, 3'b000} >> p;
        frac_bits = ext[2:0];
    endfunction

    // NOTE: every variable gets a default before the mux loop so no latch is inferred.
    always_comb begin
        cur_state = ACCUM;
        cur_cnt   = '0;
        cur_s     = '0;
        cur_d     = '0;
        cur_r     = '0;
        cur_lock  = 1'b1;
        cur_gain  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(mag_ch) == k) begin
                cur_state = state_q[k];
                cur_cnt   = cnt_q[k];
                cur_s     = s_q[k];
                cur_d     = d_q[k];
                cur_r     = r_q[k];
                cur_lock  = lock_q[k];
                cur_gain  = gain_q[k];
            end
        end

        in_range = (int'(mag_ch) < NUM_CH);
        hit      = mag_valid && in_range;
        diff     = (mag_in >= cur_r) ? (mag_in - cur_r) : (cur_r - mag_in);
        new_s    = cur_s + {{WIN_LOG2{1'b0}}, mag_in};
        new_d    = cur_d + {{WIN_LOG2{1'b0}}, diff};
        new_lock = cur_lock & mag_locked;
        win_end  = hit && (cur_state == ACCUM) && (cur_cnt == WIN_LAST);

        mean_w  = new_s[SUM_W-1:WIN_LOG2];
        noise_w = (new_d[SUM_W-1:WIN_LOG2] == '0) ? MAG_WIDTH'(1) : new_d[SUM_W-1:WIN_LOG2];

        // The cycle AGC is re-enabled belongs to the manual-gain reload, not a step.
        agc_run = agc_enable && agc_q;
        gain_up = agc_run && (mean_w < LOW_TH) && (int'(cur_gain) < GAIN_MAX);
        gain_dn = agc_run && !gain_up && (mean_w > HIGH_TH) && (cur_gain != 4'd0);

        if (gain_up)
            next_r = mean_w[MAG_WIDTH-1] ? '1 : {mean_w[MAG_WIDTH-2:0], 1'b0};
        else if (gain_dn)
            next_r = mean_w >> 1;
        else
            next_r = mean_w;
    end

    // NOTE: per-channel arrays are reset explicitly since their reset values are observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= ACCUM;
                cnt_q[k]   <= '0;
                s_q[k]     <= '0;
                d_q[k]     <= '0;
                r_q[k]     <= '0;
                lock_q[k]  <= 1'b1;
                gain_q[k]  <= 4'd4;
            end
            agc_q  <= 1'b1;
            err_ch <= 1'b0;
        end else begin
            agc_q <= agc_enable;
            if (mag_valid && !in_range)
                err_ch <= 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (!agc_enable || !agc_q)
                    gain_q[k] <= manual_gain;
                else if (hit && int'(mag_ch) == k && win_end && gain_up)
                    gain_q[k] <= gain_q[k] + 4'd1;
                else if (hit && int'(mag_ch) == k && win_end && gain_dn)
                    gain_q[k] <= gain_q[k] - 4'd1;

                if (state_q[k] == SETTLE && !agc_enable) begin
                    state_q[k] <= ACCUM;
                    cnt_q[k]   <= '0;
                end else if (hit && int'(mag_ch) == k) begin
                    if (state_q[k] == SETTLE) begin
                        if (cnt_q[k] == SET_LAST) begin
                            state_q[k] <= ACCUM;
                            cnt_q[k]   <= '0;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                        end
                    end else if (cnt_q[k] == WIN_LAST) begin
                        s_q[k]    <= '0;
                        d_q[k]    <= '0;
                        cnt_q[k]  <= '0;
                        lock_q[k] <= 1'b1;
                        r_q[k]    <= next_r;
                        if ((gain_up || gain_dn) && HAS_SETTLE)
                            state_q[k] <= SETTLE;
                    end else begin
                        s_q[k]    <= new_s;
                        d_q[k]    <= new_d;
                        lock_q[k] <= new_lock;
                        cnt_q[k]  <= cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        gain_out = '0;
        for (int k = 0; k < NUM_CH; k++)
            gain_out[4*k +: 4] = gain_q[k];
    end

    // Stage 1: capture the closing window's statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_ch    <= '0;
            p1_mean  <= '0;
            p1_noise <= '0;
            p1_lock  <= 1'b0;
        end else begin
            p1_valid <= win_end;
            if (win_end) begin
                p1_ch    <= mag_ch;
                p1_mean  <= mean_w;
                p1_noise <= noise_w;
                p1_lock  <= new_lock;
            end
        end
    end

    always_comb begin
        snr_pm   = msb_pos(p1_mean);
        snr_pn   = msb_pos(p1_noise);
        snr_v    = 8 * (snr_pm - snr_pn) + int'(frac_bits(p1_mean, snr_pm))
                   - int'(frac_bits(p1_noise, snr_pn));
        snr_calc = '0;
        if (p1_mean != '0) begin
            if (snr_v > 255)
                snr_calc = 8'd255;
            else if (snr_v > 0)
                snr_calc = 8'(snr_v);
        end
    end

    // Stage 2: registered, held result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_mean   <= '0;
            res_noise  <= '0;
            res_snr    <= '0;
            res_locked <= 1'b0;
        end else begin
            res_valid <= p1_valid;
            if (p1_valid) begin
                res_ch     <= p1_ch;
                res_mean   <= p1_mean;
                res_noise  <= p1_noise;
                res_snr    <= snr_calc;
                res_locked <= p1_lock;
            end
        end
    end

endmodule

// File: tb/tb_weak_signal_agc_snr.sv
// Scoreboard bench for weak_signal_agc_snr: a behavioural channel model queues
// expected results as samples are driven; a negedge monitor pops and compares.
module tb_weak_signal_agc_snr;

    localparam int NUM_CH = 2;
    localparam int WIN = 4;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] mag_in;
    logic [0:0]  mag_ch;
    logic        mag_locked, mag_valid, agc_enable;
    logic [3:0]  manual_gain;
    logic [7:0]  gain_out;
    logic        res_valid, res_locked, err_ch;
    logic [0:0]  res_ch;
    logic [23:0] res_mean, res_noise;
    logic [7:0]  res_snr;

    logic [1:0]  mag_ch3;
    logic        mag_valid3;
    logic [11:0] gain_out3;
    logic        res_valid3, res_locked3, err_ch3;
    logic [1:0]  res_ch3;
    logic [23:0] res_mean3, res_noise3;
    logic [7:0]  res_snr3;

    weak_signal_agc_snr #(.NUM_CH(2), .WIN_LOG2(2), .SETTLE_SAMPLES(2)) u_dut (
        .clk(clk), .rst(rst), .mag_in(mag_in), .mag_ch(mag_ch), .mag_locked(mag_locked),
        .mag_valid(mag_valid), .agc_enable(agc_enable), .manual_gain(manual_gain),
        .gain_out(gain_out), .res_valid(res_valid), .res_ch(res_ch), .res_mean(res_mean),
        .res_noise(res_noise), .res_snr(res_snr), .res_locked(res_locked), .err_ch(err_ch));

    // Three-channel instance so that an out-of-range index is representable.
    weak_signal_agc_snr #(.NUM_CH(3), .WIN_LOG2(2), .SETTLE_SAMPLES(2)) u_dut3 (
        .clk(clk), .rst(rst), .mag_in(mag_in), .mag_ch(mag_ch3), .mag_locked(mag_locked),
        .mag_valid(mag_valid3), .agc_enable(agc_enable), .manual_gain(manual_gain),
        .gain_out(gain_out3), .res_valid(res_valid3), .res_ch(res_ch3), .res_mean(res_mean3),
        .res_noise(res_noise3), .res_snr(res_snr3), .res_locked(res_locked3), .err_ch(err_ch3));

    always #5 clk = ~clk;

    typedef struct {
        int     cyc;
        int     ch;
        longint mean;
        longint noise;
        int     snr;
        bit     locked;
    } exp_t;

    exp_t   exp_q[$];
    int     cyc = 0;
    int     n_vec = 0;
    int     n_bad = 0;
    int     res3_count = 0;

    int     m_state [NUM_CH];
    int     m_cnt   [NUM_CH];
    longint m_s     [NUM_CH];
    longint m_d     [NUM_CH];
    longint m_r     [NUM_CH];
    bit     m_lock  [NUM_CH];
    int     m_gain  [NUM_CH];
    bit     m_agc = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int msb_of(input longint x);
        int p = 0;
        for (int i = 0; i < 63; i++)
            if (x >= (64'sd1 <<< i)) p = i;
        return p;
    endfunction

    function automatic int snr_model(input longint m, input longint n);
        int pm, pn, fm, fn, v;
        if (m == 0) return 0;
        pm = msb_of(m);
        pn = msb_of(n);
        fm = int'(((m * 8) / (64'sd1 <<< pm)) % 8);
        fn = int'(((n * 8) / (64'sd1 <<< pn)) % 8);
        v  = 8 * (pm - pn) + fm - fn;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic [7:0] exp_gains();
        return {4'(m_gain[1]), 4'(m_gain[0])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_state[k] = 0; m_cnt[k] = 0; m_s[k] = 0; m_d[k] = 0;
            m_r[k] = 0; m_lock[k] = 1'b1; m_gain[k] = 4;
        end
    endtask

    task automatic drive(input int ch, input longint mag, input bit lk);
        exp_t e;
        mag_ch     = 1'(ch);
        mag_in     = 24'(mag);
        mag_locked = lk;
        mag_valid  = 1'b1;
        if (m_state[ch] == 1) begin
            m_cnt[ch]++;
            if (m_cnt[ch] == SETTLE) begin
                m_state[ch] = 0;
                m_cnt[ch]   = 0;
            end
        end else begin
            m_s[ch] += mag;
            m_d[ch] += (mag >= m_r[ch]) ? (mag - m_r[ch]) : (m_r[ch] - mag);
            m_lock[ch] &= lk;
            m_cnt[ch]++;
            if (m_cnt[ch] == WIN) begin
                e.cyc    = cyc + 2;
                e.ch     = ch;
                e.mean   = m_s[ch] / WIN;
                e.noise  = (m_d[ch] / WIN == 0) ? 1 : m_d[ch] / WIN;
                e.snr    = snr_model(e.mean, e.noise);
                e.locked = m_lock[ch];
                exp_q.push_back(e);
                m_r[ch] = e.mean;
                if (m_agc && e.mean < 'h010000 && m_gain[ch] < 15) begin
                    m_gain[ch]++;
                    m_r[ch] = (2 * e.mean > 'hFFFFFF) ? 'hFFFFFF : 2 * e.mean;
                    m_state[ch] = 1;
                end else if (m_agc && e.mean > 'h700000 && m_gain[ch] > 0) begin
                    m_gain[ch]--;
                    m_r[ch] = e.mean / 2;
                    m_state[ch] = 1;
                end
                m_s[ch] = 0; m_d[ch] = 0; m_cnt[ch] = 0; m_lock[ch] = 1'b1;
            end
        end
        @(posedge clk); #1;
        mag_valid = 1'b0;
    endtask

    task automatic set_agc(input bit en, input int mg);
        agc_enable  = en;
        manual_gain = 4'(mg);
        for (int k = 0; k < NUM_CH; k++) begin
            if (!en || !m_agc) m_gain[k] = mg;
            if (!en && m_state[k] == 1) begin
                m_state[k] = 0;
                m_cnt[k]   = 0;
            end
        end
        m_agc = en;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("res_missing", 64'd0, 64'd1);
                exp_q.delete(0);
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_spurious", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_cycle",  64'(cyc), 64'(e.cyc));
                    check("res_ch",     64'(res_ch), 64'(e.ch));
                    check("res_mean",   64'(res_mean), 64'(e.mean));
                    check("res_noise",  64'(res_noise), 64'(e.noise));
                    check("res_snr",    64'(res_snr), 64'(e.snr));
                    check("res_locked", 64'(res_locked), 64'(e.locked));
                end
            end
            if (res_valid3) res3_count++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mag_valid = 1'b0; mag_valid3 = 1'b0; mag_in = '0; mag_ch = '0;
        mag_ch3 = '0; mag_locked = 1'b1; agc_enable = 1'b1; manual_gain = 4'd4;
        model_reset();
        idle(3);
        check("rst_gain",  64'(gain_out), 64'h44);
        check("rst_gain3", 64'(gain_out3), 64'h444);
        check("rst_res",   64'({res_valid, res_ch, res_mean, res_noise, res_snr, res_locked}), 64'd0);
        check("rst_err",   64'({err_ch, err_ch3}), 64'd0);
        rst = 1'b0;
        idle(2);

        // Mid-scale steady signal, reference still zero: gain holds.
        repeat (4) drive(0, 'h200000, 1'b1);
        drain();
        check("ch0_mean", 64'(res_mean), 64'h200000);
        check("ch0_noise", 64'(res_noise), 64'h200000);
        check("gain_hold", 64'(gain_out), 64'(exp_gains()));

        // Weak channel 1: gain up, two samples discarded, then a fresh window.
        repeat (4) drive(1, 'h001000, 1'b1);
        check("gain1_up", 64'(gain_out[7:4]), 64'd5);
        repeat (2) drive(1, 'h300000, 1'b1);
        repeat (4) drive(1, 'h002000, 1'b1);
        drain();
        check("ch1_mean2", 64'(res_mean), 64'h002000);
        check("gains_b", 64'(gain_out), 64'(exp_gains()));

        // Near full-scale: gain down, then a window with one unlocked sample.
        repeat (4) drive(0, 'h7FFFFF, 1'b1);
        check("gain0_dn", 64'(gain_out[3:0]), 64'd3);
        repeat (2) drive(0, 'h000000, 1'b1);
        drive(0, 'h400000, 1'b1);
        drive(0, 'h400001, 1'b0);
        repeat (2) drive(0, 'h400000, 1'b1);
        drain();
        check("unlocked", 64'(res_locked), 64'd0);

        // Interleaved channels closing on consecutive cycles.
        repeat (2) drive(1, 'h000100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 'h100000 + 16 * i, 1'b1);
            drive(1, 'h080000 - 32 * i, 1'b1);
        end
        drain();
        check("gains_c", 64'(gain_out), 64'(exp_gains()));

        // Mean far below deviation: SNR clamps at zero.
        repeat (4) drive(0, 'h000010, 1'b1);
        drain();
        check("snr_floor", 64'(res_snr), 64'd0);

        // Out-of-range channel on the three-channel instance.
        mag_ch3 = 2'd3; mag_valid3 = 1'b1; mag_in = 24'h123456;
        idle(1);
        mag_valid3 = 1'b0;
        idle(3);
        check("err_set",   64'(err_ch3), 64'd1);
        check("err_nochg", 64'(gain_out3), 64'h444);
        check("err_main",  64'(err_ch), 64'd0);

        // Manual gain with AGC off; channel 0 leaves SETTLE and gains never step.
        set_agc(1'b0, 9);
        check("manual9", 64'(gain_out), 64'h99);
        check("manual9_3", 64'(gain_out3), 64'h999);
        repeat (4) drive(0, 'h000800, 1'b1);
        drain();
        check("manual_hold", 64'(gain_out), 64'(exp_gains()));
        set_agc(1'b1, 7);
        check("agc_restart", 64'(gain_out), 64'h77);

        // Reset in mid-window discards partial sums.
        repeat (2) drive(0, 'h123456, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_gain", 64'(gain_out), 64'h44);
        check("rst_err_clr", 64'(err_ch3), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(3);
        check("rst_no_res", 64'(exp_q.size()), 64'd0);
        repeat (4) drive(0, 'h200000, 1'b1);
        drain();
        check("post_rst_noise", 64'(res_noise), 64'h200000);
        check("post_rst_gain", 64'(gain_out), 64'h44);

        idle(4);
        check("pending", 64'(exp_q.size()), 64'd0);
        check("dut3_res", 64'(res3_count), 64'd0);
        check("dut3_hold", 64'({res_ch3, res_mean3, res_noise3, res_snr3, res_locked3}), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
